// File: rtl/bcd_recoder_serial.sv
// bcd_recoder_serial
//   Digit-serial BCD-8421 -> BCD-4221 (optionally BCD-5211) recoder that feeds
//   the partial-product generator of the decimal multiplier. DPC digits are
//   recoded per clock, so one operand takes NDIG/DPC BUSY cycles. PAD_DIG zero
//   digits sit above the recoded operand to give downstream carry headroom.
//
//   Optional feature macro: BCD_RECODE_5211_EN
//     defined   : mode selects 4221 (0) or 5211 (1), latched with each operand
//     undefined : mode is ignored, 4221 only, no 5211 lookup is built
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand valid
//   in_ready   out  block can accept an operand (IDLE only)
//   x_in       in   4*NDIG BCD-8421 operand, digit 0 at [3:0]
//   mode       in   0 = 4221, 1 = 5211 (sampled with the operand)
//   out_valid  out  result valid (DONE state)
//   out_ready  in   consumer accepts the result
//   x_out      out  4*(NDIG+PAD_DIG) recoded result, pad digits zero
//   err        out  operand held a digit > 9; valid with out_valid
module bcd_recoder_serial #(
  parameter int NDIG    = 4,
  parameter int DPC     = 1,
  parameter int PAD_DIG = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4*NDIG-1:0]             x_in,
  input  logic                          mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*(NDIG+PAD_DIG)-1:0]   x_out,
  output logic                          err
);

  localparam int NBEAT = NDIG / DPC;
  localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Invalid codes (1010..1111) fall to the default and recode to 0000.
  function automatic logic [3:0] rec_4221(input logic [3:0] d);
    case (d)
      4'd0:    rec_4221 = 4'b0000;
      4'd1:    rec_4221 = 4'b0001;
      4'd2:    rec_4221 = 4'b0010;
      4'd3:    rec_4221 = 4'b0011;
      4'd4:    rec_4221 = 4'b1000;
      4'd5:    rec_4221 = 4'b1001;
      4'd6:    rec_4221 = 4'b1010;
      4'd7:    rec_4221 = 4'b1011;
      4'd8:    rec_4221 = 4'b1110;
      4'd9:    rec_4221 = 4'b1111;
      default: rec_4221 = 4'b0000;
    endcase
  endfunction

`ifdef BCD_RECODE_5211_EN
  function automatic logic [3:0] rec_5211(input logic [3:0] d);
    case (d)
      4'd0:    rec_5211 = 4'b0000;
      4'd1:    rec_5211 = 4'b0001;
      4'd2:    rec_5211 = 4'b0100;
      4'd3:    rec_5211 = 4'b0101;
      4'd4:    rec_5211 = 4'b0111;
      4'd5:    rec_5211 = 4'b1000;
      4'd6:    rec_5211 = 4'b1001;
      4'd7:    rec_5211 = 4'b1100;
      4'd8:    rec_5211 = 4'b1101;
      4'd9:    rec_5211 = 4'b1111;
      default: rec_5211 = 4'b0000;
    endcase
  endfunction
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*NDIG-1:0]   src_q, src_d;     // source digits, shifted right each beat
  logic [4*NDIG-1:0]   acc_q, acc_d;     // result under construction
  logic [4*NDIG-1:0]   xout_q, xout_d;   // presented result, updated only on completion
  logic                err_acc_q, err_acc_d;
  logic                err_q, err_d;

`ifdef BCD_RECODE_5211_EN
  logic                mode_q, mode_d;
`else
  logic                unused_mode;
  assign unused_mode = mode;
`endif

  logic [4*DPC-1:0]    rec_beat;
  logic                bad_beat;

  // Recode the DPC lowest source digits of the current beat.
  always_comb begin
    rec_beat = '0;
    bad_beat = 1'b0;
    for (int k = 0; k < DPC; k++) begin
      if (src_q[4*k +: 4] > 4'd9) bad_beat = 1'b1;
`ifdef BCD_RECODE_5211_EN
      rec_beat[4*k +: 4] = mode_q ? rec_5211(src_q[4*k +: 4]) : rec_4221(src_q[4*k +: 4]);
`else
      rec_beat[4*k +: 4] = rec_4221(src_q[4*k +: 4]);
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    acc_d     = acc_q;
    xout_d    = xout_q;
    err_acc_d = err_acc_q;
    err_d     = err_q;
`ifdef BCD_RECODE_5211_EN
    mode_d    = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          src_d     = x_in;
          acc_d     = '0;
          err_acc_d = 1'b0;
          cnt_d     = '0;
`ifdef BCD_RECODE_5211_EN
          mode_d    = mode;
`endif
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // Beat cnt_q produces result digits cnt_q*DPC .. cnt_q*DPC+DPC-1.
        for (int k = 0; k < DPC; k++) begin
          acc_d[4*(int'(cnt_q)*DPC + k) +: 4] = rec_beat[4*k +: 4];
        end
        err_acc_d = err_acc_q | bad_beat;
        src_d     = src_q >> (4*DPC);
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish the finished word together with its sticky error flag.
          xout_d  = acc_d;
          err_d   = err_acc_d;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      src_q     <= '0;
      acc_q     <= '0;
      xout_q    <= '0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef BCD_RECODE_5211_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      acc_q     <= acc_d;
      xout_q    <= xout_d;
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
`ifdef BCD_RECODE_5211_EN
      mode_q    <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign err       = err_q;

  always_comb begin
    x_out             = '0;
    x_out[4*NDIG-1:0] = xout_q;
  end

endmodule

// File: tb/tb_bcd_recoder_serial.sv
module tb_bcd_recoder_serial;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // DUT 1: NDIG=4, DPC=1, PAD_DIG=1
  logic        in_valid, in_ready, mode, out_valid, out_ready, err;
  logic [15:0] x_in;
  logic [19:0] x_out;

  // DUT 2: NDIG=4, DPC=2, PAD_DIG=1
  logic        in_valid2, in_ready2, mode2, out_valid2, out_ready2, err2;
  logic [15:0] x_in2;
  logic [19:0] x_out2;

  bcd_recoder_serial #(.NDIG(4), .DPC(1), .PAD_DIG(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .err(err)
  );

  bcd_recoder_serial #(.NDIG(4), .DPC(2), .PAD_DIG(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .x_in(x_in2), .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2),
    .x_out(x_out2), .err(err2)
  );

  typedef struct {
    logic [19:0] x;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] T4221 [0:9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
  logic [3:0] T5211 [0:9] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hC, 4'hD, 4'hF};

  function automatic exp_t model(input logic [15:0] x, input logic m);
    exp_t  r;
    logic  use5211;
    logic [3:0] d;
`ifdef BCD_RECODE_5211_EN
    use5211 = m;
`else
    use5211 = 1'b0;
`endif
    r.x = '0;
    r.e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = x[4*i +: 4];
      if (d > 4'd9) r.e = 1'b1;
      else r.x[4*i +: 4] = use5211 ? T5211[d] : T4221[d];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand into DUT 1; returns at the negedge after acceptance.
  task automatic send(input logic [15:0] x, input logic m, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x_in     = x;
    mode     = m;
    if (push) sbq.push_back(model(x, m));
    @(negedge clk);
    in_valid = 1'b0;
    x_in     = 16'hFFFF;
  endtask

  // Wait for the result, check latency and value, optionally stall hold cycles.
  task automatic recv(input string tag, input int exp_lat, input int hold);
    int   lat = 0;
    exp_t e;
    logic [19:0] xs;
    logic        es;
    check({tag, "_inrdy_busy"}, {31'd0, in_ready}, 32'd0);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_x_out"}, {12'd0, x_out}, {12'd0, e.x});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e.e});
    end
    xs = x_out;
    es = err;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_x"}, {12'd0, x_out}, {12'd0, xs});
      check({tag, "_hold_err"}, {31'd0, err}, {31'd0, es});
      check({tag, "_hold_inrdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_x_kept"}, {12'd0, x_out}, {12'd0, xs});
    check({tag, "_inrdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    exp_t        e2;
    int          lat2;
    logic [15:0] rx;
    logic        rm;

    rst = 1'b1;
    in_valid = 1'b0; x_in = '0; mode = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; x_in2 = '0; mode2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_x_out", {12'd0, x_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic 4221 recode
    send(16'h9051, 1'b0, 1'b1);
    recv("w9051", 4, 0);

    // Back-to-back words
    send(16'h1234, 1'b0, 1'b1);
    recv("w1234", 4, 0);
    send(16'h0000, 1'b0, 1'b1);
    recv("w0000", 4, 0);

    // Invalid digit, then err cleared on the next word
    send(16'h12A4, 1'b0, 1'b1);
    recv("w12A4", 4, 0);
    send(16'h0001, 1'b0, 1'b1);
    recv("w0001", 4, 0);

    // Backpressure for 5 cycles, mode=1 (5211 only with the feature built)
    send(16'h9051, 1'b1, 1'b1);
    recv("bp9051", 4, 5);

    // Reset in the second BUSY cycle aborts the word
    send(16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_x_out", {12'd0, x_out}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("abort_no_result", {31'd0, out_valid}, 32'd0);
    send(16'h0007, 1'b0, 1'b1);
    recv("w0007", 4, 0);

    // Random words, including invalid digits and both modes
    for (int t = 0; t < 10; t++) begin
      rx = 16'($urandom);
      rm = 1'($urandom);
      send(rx, rm, 1'b1);
      recv("rand", 4, int'($urandom_range(0, 2)));
    end

    // DPC=2 instance: two beats per word
    in_valid2 = 1'b1;
    x_in2     = 16'h9051;
    mode2     = 1'b1;
    e2        = model(16'h9051, 1'b1);
    @(negedge clk);
    in_valid2 = 1'b0;
    check("d2_inrdy_busy", {31'd0, in_ready2}, 32'd0);
    lat2 = 0;
    while (!out_valid2 && lat2 < 50) begin
      @(negedge clk);
      lat2++;
    end
    check("d2_latency", lat2, 2);
    check("d2_x_out", {12'd0, x_out2}, {12'd0, e2.x});
    check("d2_err", {31'd0, err2}, {31'd0, e2.e});
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("d2_valid_drop", {31'd0, out_valid2}, 32'd0);
    check("d2_inrdy_back", {31'd0, in_ready2}, 32'd1);

    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
